// File: rtl/fp_arith_pkg.sv
// Shared fixed-point arithmetic definitions.
// Used by the sequential multiplier and divider.
package fp_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 10;
  localparam int DEF_FRAC  = 4;

  // OR of product bits above the result window.
  function automatic logic ov_slice(
    input logic [63:0] full,
    input int          w,
    input int          f
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i >= f + w && i < 2 * w) begin
        r = r | full[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-add multiply datapath.
// Retires one multiplier bit per step.
module shift_add_datapath
  import fp_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  always_comb begin
    addend = mplr[0] ? mcand : '0;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + {1'b0, addend};
  end

  // Carry lands in the top bit as the
  // accumulator shifts right.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= a;
      mplr  <= b;
      acc   <= '0;
    end else if (step) begin
      acc  <= {sum, acc[WIDTH-1:1]};
      mplr <= mplr >> 1;
    end
  end

  assign prod = acc;

endmodule

// File: rtl/fixed_point_multiplier.sv
// Sequential unsigned fixed-point multiplier.
// Truncated product plus overflow flag.
module fixed_point_multiplier
  import fp_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] p,
  output logic             ov,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] prod;
  logic               load;
  logic               step;

  assign load = (state == IDLE) && start;
  assign step = (state == CALC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (ld_a) a_reg <= A;
      if (ld_b) b_reg <= B;
    end
  end

  shift_add_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (a_reg),
    .b    (b_reg),
    .prod (prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= '0;
      ov    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          p     <= prod[FRAC+WIDTH-1:FRAC];
          ov    <= ov_slice(64'(prod), WIDTH, FRAC);
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Bench for fixed_point_multiplier.
// Behavioural model plus directed vectors.
module tb_fixed_point_multiplier;

  localparam int W = 10;
  localparam int F = 4;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         ld_a  = 1'b0;
  logic         ld_b  = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic [W-1:0] p;
  logic         ov;
  logic         busy;
  logic         done;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fixed_point_multiplier #(
    .WIDTH(W),
    .FRAC (F)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .ld_a (ld_a),
    .ld_b (ld_b),
    .A    (A),
    .B    (B),
    .p    (p),
    .ov   (ov),
    .busy (busy),
    .done (done)
  );

  task automatic chk(input string name, input int got,
                     input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s got=%0d want=%0d", name, got, want);
  endtask

  // Model: operand regs, a countdown of remaining
  // cycles, and the product from plain arithmetic.
  int     a_r = 0;
  int     b_r = 0;
  int     left = 0;
  int     res_p = 0;
  bit     res_ov = 0;
  longint full = 0;
  int     exp_p = 0;
  bit     exp_ov = 0;
  bit     exp_busy = 0;
  bit     exp_done = 0;
  bit     chk_en = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r = 0; b_r = 0; left = 0;
      exp_p = 0; exp_ov = 0;
      exp_busy = 0; exp_done = 0;
    end else begin
      exp_done = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          exp_p = res_p;
          exp_ov = res_ov;
          exp_done = 1;
        end
      end else if (start) begin
        full = longint'(a_r) * longint'(b_r);
        res_p = int'((full >> F) % (64'd1 << W));
        res_ov = (full >> (F + W)) != 0;
        left = W + 1;
      end
      if (ld_a) a_r = int'(A);
      if (ld_b) b_r = int'(B);
      exp_busy = (left > 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc p", int'(p), exp_p);
      chk("cyc ov", int'(ov), int'(exp_ov));
      chk("cyc busy", int'(busy), int'(exp_busy));
      chk("cyc done", int'(done), int'(exp_done));
    end
  end

  task automatic load_ab(input int a, input int b);
    @(negedge clk);
    A = W'(a); B = W'(b); ld_a = 1; ld_b = 1;
    @(negedge clk);
    ld_a = 0; ld_b = 0;
  endtask

  task automatic pulse_start;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string name, output int k);
    k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk({name, " timeout"}, 0, 1);
  endtask

  task automatic run_op(input string name, input int a,
                        input int b, input int ep,
                        input int eov);
    int k;
    load_ab(a, b);
    pulse_start;
    wait_done(name, k);
    chk({name, " latency"}, k, W + 1);
    chk({name, " p"}, int'(p), ep);
    chk({name, " ov"}, int'(ov), eov);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int k2;
    #1 rst = 0;
    repeat (2) @(negedge clk);
    chk("reset p", int'(p), 0);
    chk("reset ov", int'(ov), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    rst = 1;
    chk_en = 1;

    // 2.5 * 3.0 = 7.5
    load_ab(40, 48);
    pulse_start;
    repeat (4) @(negedge clk);
    chk("basic busy mid", int'(busy), 1);
    wait_done("basic", k);
    chk("basic latency", k + 4, W + 1);
    chk("basic p", int'(p), 120);
    chk("basic ov", int'(ov), 0);
    chk("basic busy at done", int'(busy), 0);

    run_op("ovf", 1023, 1023, 896, 1);
    run_op("trunc", 1, 1, 0, 0);
    run_op("zero", 0, 777, 0, 0);

    // Mid-CALC start and ld_a must not disturb
    load_ab(40, 48);
    pulse_start;
    repeat (3) @(negedge clk);
    start = 1; ld_a = 1; A = 10'd16;
    @(negedge clk);
    start = 0; ld_a = 0;
    wait_done("overlap", k);
    chk("overlap latency", k + 4, W + 1);
    chk("overlap p", int'(p), 120);
    // start in done cycle, with ld_a on same edge
    A = 10'd100; ld_a = 1; start = 1;
    @(negedge clk);
    start = 0; ld_a = 0;
    wait_done("oldA", k);
    chk("oldA latency", k, W + 1);
    chk("oldA p", int'(p), 48);
    chk("oldA ov", int'(ov), 0);

    // Back-to-back, new B loaded during CALC
    load_ab(40, 48);
    pulse_start;
    repeat (2) @(negedge clk);
    B = 10'd16; ld_b = 1;
    @(negedge clk);
    ld_b = 0;
    wait_done("b2b first", k);
    chk("b2b first p", int'(p), 120);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("b2b second", k2);
    chk("b2b interval", k2 + 1, W + 2);
    chk("b2b p", int'(p), 40);
    chk("b2b ov", int'(ov), 0);

    // Asynchronous reset mid-CALC
    load_ab(40, 48);
    pulse_start;
    repeat (5) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("arst p", int'(p), 0);
    chk("arst ov", int'(ov), 0);
    chk("arst busy", int'(busy), 0);
    chk("arst done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (14) @(negedge clk);
    chk("arst no done", int'(done), 0);
    run_op("post reset", 40, 48, 120, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
